// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial pattern-detection controller
// Holds pattern/length/overlap/threshold config and sequences detection IDLE -> RUN -> DONE.
module seq_detect_ctrl #(
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [PAT_MAX-1:0]         cfg_pattern,
    input  logic [$clog2(PAT_MAX):0]   cfg_len,
    input  logic                       cfg_overlap,
    input  logic [CNT_W-1:0]           cfg_threshold,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       bit_valid,
    input  logic                       bit_in,
    output logic                       bit_ready,
    output logic                       match,
    output logic [CNT_W-1:0]           match_count,
    output logic                       busy,
    output logic                       done,
    output logic                       irq,
    output logic                       cfg_err
);

    localparam int LEN_W = $clog2(PAT_MAX) + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state, w_state_next;
    logic [PAT_MAX-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_threshold;
    logic [PAT_MAX-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [CNT_W-1:0]   r_count;
    logic               r_match;
    logic               r_irq;
    logic               r_cfg_err;

    logic               w_restart;
    logic               w_len_ok;
    logic               w_eval;
    logic [PAT_MAX-1:0] w_hist_new;
    logic [LEN_W-1:0]   w_fill_new;
    logic [PAT_MAX-1:0] w_mask;
    logic               w_hit;
    logic [CNT_W-1:0]   w_count_new;

    assign w_restart   = start && !stop;
    assign w_len_ok    = (r_len != '0) && (r_len <= MAX_LEN);
    // A bit taken during a restart cycle is dropped; during a stop cycle it still counts.
    assign w_eval      = (r_state == RUN) && bit_valid && (stop || !start);
    assign w_hist_new  = {r_hist[PAT_MAX-2:0], bit_in};
    assign w_fill_new  = (r_fill == MAX_LEN) ? r_fill : r_fill + 1'b1;
    assign w_count_new = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + 1'b1;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    assign w_hit = w_eval && (w_fill_new >= r_len) &&
                   (((w_hist_new ^ r_pattern) & w_mask) == '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_restart && w_len_ok) w_state_next = RUN;
            RUN: begin
                if (stop)
                    w_state_next = IDLE;
                else if (!start && w_hit && (r_threshold != '0) && (w_count_new == r_threshold))
                    w_state_next = DONE;
            end
            DONE: begin
                if (stop)
                    w_state_next = IDLE;
                else if (start)
                    w_state_next = RUN;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern   <= '0;
            r_len       <= LEN_W'(1);
            r_overlap   <= 1'b0;
            r_threshold <= '0;
            r_hist      <= '0;
            r_fill      <= '0;
            r_count     <= '0;
            r_match     <= 1'b0;
            r_irq       <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_match <= w_hit;
            r_irq   <= (w_state_next == DONE) && (r_state != DONE);
            case (r_state)
                IDLE: begin
                    if (cfg_we) begin
                        r_pattern   <= cfg_pattern;
                        r_len       <= cfg_len;
                        r_overlap   <= cfg_overlap;
                        r_threshold <= cfg_threshold;
                        r_cfg_err   <= 1'b0;
                    end
                    if (w_restart) begin
                        if (w_len_ok) begin
                            r_hist  <= '0;
                            r_fill  <= '0;
                            r_count <= '0;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_restart) begin
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_count <= '0;
                    end else if (w_eval) begin
                        r_hist <= w_hist_new;
                        r_fill <= (w_hit && !r_overlap) ? '0 : w_fill_new;
                        if (w_hit) r_count <= w_count_new;
                    end
                end
                DONE: begin
                    if (w_restart) begin
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bit_ready   = (r_state == RUN);
    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign match       = r_match;
    assign match_count = r_count;
    assign irq         = r_irq;
    assign cfg_err     = r_cfg_err;

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run-time programmable serial pattern-detection controller for the bit-stream detector datapath. It holds the configured pattern, length, overlap mode and match threshold, and sequences detection through an IDLE/RUN/DONE state machine. It accepts stream bits over a valid/ready handshake, counts matches and raises a done flag and a one-cycle irq when the count reaches the threshold. It sits between the configuration/host interface and the serial data source.

Parameters:
PAT_MAX, 8, maximum pattern length in bits (at least 2).
CNT_W, 8, width of the match counter and threshold.

Ports:
clk  input  1  clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
cfg_we  input  1  configuration write strobe; honoured in IDLE only.
cfg_pattern  input  PAT_MAX  pattern; bit 0 is the most recently received bit.
cfg_len  input  clog2(PAT_MAX)+1  pattern length; legal range 1..PAT_MAX.
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
cfg_threshold  input  CNT_W  match count that ends a run; 0 = run until stopped.
start  input  1  start (or restart) a detection run.
stop  input  1  abort the run and return to IDLE.
bit_valid  input  1  stream bit present.
bit_in  input  1  stream bit.
bit_ready  output  1  controller accepts a bit this cycle.
match  output  1  registered one-cycle pulse per detected match.
match_count  output  CNT_W  matches counted in the current or last run.
busy  output  1  high in RUN.
done  output  1  high in DONE.
irq  output  1  one-cycle pulse on entry to DONE.
cfg_err  output  1  sticky flag: last start was refused because cfg_len was illegal.

Behaviour:
- Reset: state=IDLE. Stored pattern=0, len=1, overlap=0, threshold=0. History, fill and match_count=0. bit_ready, match, busy, done, irq, cfg_err all 0.
- Config: cfg_we in IDLE latches all four cfg_* fields and clears cfg_err. cfg_we in RUN or DONE is ignored.
- States:
  - IDLE: bit_ready=0; stream bits are neither consumed nor recorded.
  - start with stored len in 1..PAT_MAX goes to RUN next cycle and clears history, fill and match_count.
  - start with an illegal len stays in IDLE and sets cfg_err.
- RUN: busy=1, bit_ready=1.
  - A bit is accepted when bit_valid and bit_ready are both high.
  - On acceptance: hist <= {hist[PAT_MAX-2:0], bit_in}; fill increments, saturating at PAT_MAX.
  - Hit condition: new fill >= len and the low len bits of the new hist equal the low len bits of the pattern.
  - On a hit, match pulses high in the following cycle (latency 1 from the accepting edge).
  - On a hit, match_count increments, saturating at 2^CNT_W-1.
  - Non-overlap mode: a hit also sets fill to 0, so the next match needs len fresh bits. Overlap mode: fill is kept.
  - If threshold != 0 and the new count equals threshold, go to DONE in the same edge as the increment.
- DONE: done=1, bit_ready=0, match_count held. irq pulses only in the first DONE cycle.
  - start restarts into RUN, clearing the count.
  - stop returns to IDLE; done drops and the count is retained.
- stop in RUN: go to IDLE. A bit accepted in that same cycle is still evaluated, so match and count may update on that edge; no DONE entry from that edge.
- start in RUN: restart, clearing history, fill and count. Any bit accepted in that cycle is discarded.
- start and stop together: stop wins in every state.
- Threshold 0: DONE is never entered and the counter saturates.
- Reset asserted mid-run overrides everything and returns all state to the reset values.

Test Plan:
1. Reset, then cfg pattern=4'b1010 (bit 0 = last bit), len=4, overlap=1, threshold=0, start; stream 1,0,1,0,1,0,0 -> match pulses one cycle after the 4th and 6th bits; match_count=2; busy=1; done=0.
2. Same stream with overlap=0 -> single match after the 4th bit; match_count=1.
3. overlap=1, threshold=2, stream 1,0,1,0,1,0,1 -> DONE entered on the 6th-bit edge; irq high for exactly 1 cycle; bit_ready=0 afterwards; 7th bit not consumed; match_count=2 held.
4. cfg_len=0, start -> stays in IDLE, cfg_err=1. Then cfg_we with len=4 -> cfg_err=0; start -> busy=1.
5. start and stop asserted in the same RUN cycle -> IDLE, count retained. cfg_we during RUN -> stored pattern unchanged (verify with a follow-up run).
6. CNT_W=2, threshold=0, stream of 5 overlapping matches -> match_count saturates at 3 while match still pulses 5 times. Reset mid-run -> all outputs return to 0.
